// File: rtl/bus_stall_bridge.sv
// Avalon-style stall-injecting bridge between a CPU master port and a RAM slave.
// Each CPU request is registered. An LFSR then inserts 0..MAX_STALL wait cycles
// before the request is forwarded to the slave. Master-side protocol violations
// raise a sticky flag. The bridge is meant for CPU benches that exercise
// waitrequest handling.
module bus_stall_bridge #(
  parameter int unsigned MAX_STALL    = 7,
  parameter int unsigned STALL_ENABLE = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_address,
  input  logic        m_read,
  input  logic        m_write,
  input  logic [3:0]  m_byteenable,
  input  logic [31:0] m_writedata,
  output logic        m_waitrequest,
  output logic [31:0] m_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [3:0]  s_byteenable,
  output logic [31:0] s_writedata,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic        protocol_error,
  output logic [15:0] txn_count
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, STALL, ISSUE, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] lfsr;
  logic [7:0]  stall_cnt;
  logic [7:0]  stall_now;

  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  be_p0;
  logic        rd_p0;
  logic        wr_p0;

  logic        one_req;
  logic        both_req;
  logic        mismatch;
  logic        issue_rd;
  logic        issue_wr;

  // Galois step for x^16 + x^14 + x^13 + x^11 (right-shifting form).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Number of wait cycles for a transfer, drawn from the low LFSR byte.
  function automatic logic [7:0] stall_pick(input logic [7:0] r);
    logic [31:0] m;
    if (STALL_ENABLE == 0) begin
      m = 32'd0;
    end else begin
      m = 32'(r) % (MAX_STALL + 32'd1);
    end
    stall_pick = m[7:0];
  endfunction

  assign one_req   = m_read ^ m_write;
  assign both_req  = m_read & m_write;
  assign stall_now = stall_pick(lfsr[7:0]);

  // The master must hold the whole request steady until it completes.
  // Write data matters only when the transfer is a write.
  assign mismatch = (m_read != rd_p0) | (m_write != wr_p0) |
                    (m_address != addr_p0) | (m_byteenable != be_p0) |
                    (wr_p0 & (m_writedata != wdata_p0));

  // On the direct IDLE->ISSUE path the capture registers still hold the old
  // request, so the strobes come straight from the master pins.
  assign issue_rd = (state == IDLE) ? m_read  : rd_p0;
  assign issue_wr = (state == IDLE) ? m_write : wr_p0;

  assign m_waitrequest = (m_read | m_write) & (state != DONE);

  assign s_address    = addr_p0;
  assign s_byteenable = be_p0;
  assign s_writedata  = wdata_p0;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (one_req) state_nxt = (stall_now != 8'd0) ? STALL : ISSUE;
      STALL:   if (stall_cnt == 8'd1) state_nxt = ISSUE;
      ISSUE:   if (!s_waitrequest) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Free-running stall source, stepping on every clock outside reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= SEED_EFF;
    else       lfsr <= lfsr_step(lfsr);
  end

  // Request capture stage (p0) and stall countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_p0   <= '0;
      wdata_p0  <= '0;
      be_p0     <= '0;
      rd_p0     <= 1'b0;
      wr_p0     <= 1'b0;
      stall_cnt <= '0;
    end else if (state == IDLE && one_req) begin
      addr_p0   <= m_address;
      wdata_p0  <= m_writedata;
      be_p0     <= m_byteenable;
      rd_p0     <= m_read;
      wr_p0     <= m_write;
      stall_cnt <= stall_now;
    end else if (state == STALL) begin
      stall_cnt <= stall_cnt - 8'd1;
    end
  end

  // Slave strobes are high exactly while the bridge sits in ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_read  <= 1'b0;
      s_write <= 1'b0;
    end else begin
      s_read  <= (state_nxt == ISSUE) & issue_rd;
      s_write <= (state_nxt == ISSUE) & issue_wr;
    end
  end

  // Read return, completion counter and sticky protocol flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_readdata     <= '0;
      txn_count      <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (state == ISSUE && !s_waitrequest && rd_p0) m_readdata <= s_readdata;
      if (state == DONE) txn_count <= txn_count + 16'd1;
      if ((state == IDLE && both_req) || (state != IDLE && mismatch))
        protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_stall_bridge.sv
// Self-checking bench for bus_stall_bridge. A scoreboard is filled at request
// time from a RAM/LFSR reference model. A negedge monitor checks every CPU
// completion against it.
module tb_bus_stall_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  // Stalling bridge under random traffic
  logic [31:0] m_address = '0, m_writedata = '0, m_readdata;
  logic        m_read = 1'b0, m_write = 1'b0, m_waitrequest;
  logic [3:0]  m_byteenable = '0, s_byteenable;
  logic [31:0] s_address, s_writedata, s_readdata = '0;
  logic        s_read, s_write, s_waitrequest = 1'b0, protocol_error;
  logic [15:0] txn_count;

  // Bridge with stalls disabled, used for the fixed-latency case
  logic [31:0] n_m_address = '0, n_m_writedata = '0, n_m_readdata;
  logic        n_m_read = 1'b0, n_m_write = 1'b0, n_m_waitrequest;
  logic [3:0]  n_m_byteenable = '0, n_s_byteenable;
  logic [31:0] n_s_address, n_s_writedata, n_s_readdata = 32'hDEADBEEF;
  logic        n_s_read, n_s_write, n_s_waitrequest = 1'b0, n_protocol_error;
  logic [15:0] n_txn_count;

  bus_stall_bridge #(.MAX_STALL(7), .STALL_ENABLE(1), .LFSR_SEED(16'hACE1)) u_dut (
    .clk(clk), .reset(reset),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_byteenable(s_byteenable), .s_writedata(s_writedata),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .protocol_error(protocol_error), .txn_count(txn_count)
  );

  bus_stall_bridge #(.MAX_STALL(7), .STALL_ENABLE(0), .LFSR_SEED(16'hACE1)) u_nostall (
    .clk(clk), .reset(reset),
    .m_address(n_m_address), .m_read(n_m_read), .m_write(n_m_write),
    .m_byteenable(n_m_byteenable), .m_writedata(n_m_writedata),
    .m_waitrequest(n_m_waitrequest), .m_readdata(n_m_readdata),
    .s_address(n_s_address), .s_read(n_s_read), .s_write(n_s_write),
    .s_byteenable(n_s_byteenable), .s_writedata(n_s_writedata),
    .s_waitrequest(n_s_waitrequest), .s_readdata(n_s_readdata),
    .protocol_error(n_protocol_error), .txn_count(n_txn_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: feedback polynomial x^16 + x^14 + x^13 + x^11.
  // In right-shifting Galois form, term x^k feeds bit k-1.
  localparam logic [15:0] POLY = (16'h1 << 15) | (16'h1 << 13) | (16'h1 << 12) | (16'h1 << 10);
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge reset)
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= (lfsr_m >> 1) ^ (lfsr_m[0] ? POLY : 16'h0000);

  // Slave RAM: 16 words, with next_waits wait cycles per access
  logic [31:0] ram     [16] = '{default: 32'h0};
  logic [31:0] ref_ram [16] = '{default: 32'h0};
  int next_waits = 0;
  int waited = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      waited <= 0;
    end else if (s_read | s_write) begin
      if (s_waitrequest) begin
        waited <= waited + 1;
      end else begin
        waited <= 0;
        if (s_write)
          for (int b = 0; b < 4; b++)
            if (s_byteenable[b]) ram[s_address[5:2]][b*8 +: 8] <= s_writedata[b*8 +: 8];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    s_waitrequest = (s_read | s_write) && (waited < next_waits);
    s_readdata    = ram[s_address[5:2]];
  end

  // Scoreboard
  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          start;
    int          lat;
  } exp_t;
  exp_t sb[$];

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset && (m_read | m_write) && !m_waitrequest) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_completion");
      end else begin
        e = sb.pop_front();
        check("latency", 32'(cyc - e.start), 32'(e.lat));
        if (e.rd) check("rdata", m_readdata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Call from an IDLE cycle, before the request is driven.
  task automatic push_exp(input logic rd, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input int waits);
    exp_t e;
    int stall;
    stall = int'(lfsr_m[7:0]) % 8;
    next_waits = waits;
    e.rd    = rd;
    e.start = cyc;
    e.lat   = 2 + stall + waits;
    e.data  = ref_ram[a[5:2]];
    if (!rd)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_ram[a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
    sb.push_back(e);
  endtask

  task automatic drive(input logic rd, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    m_read = rd; m_write = !rd; m_address = a; m_byteenable = be; m_writedata = wd;
  endtask

  task automatic idle();
    m_read = 1'b0; m_write = 1'b0;
  endtask

  // Wait for the DONE cycle and count the cycles a slave strobe was high.
  // Returns at the following IDLE cycle.
  task automatic wait_done(output int busy);
    int n;
    busy = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_read | s_write) busy++;
      if (m_waitrequest === 1'b0) break;
      n++;
      if (n > 300) begin
        fail_now("completion_timeout");
        sb.delete();
        idle();
        break;
      end
    end
    tick();
  endtask

  task automatic xfer(input logic rd, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, input int waits);
    int busy;
    push_exp(rd, a, be, wd, waits);
    drive(rd, a, be, wd);
    wait_done(busy);
    check("slave_strobe_cycles", 32'(busy), 32'(waits + 1));
  endtask

  initial begin
    int busy;
    int n;
    int stall;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_s_read", {31'd0, s_read}, 32'd0);
    check("rst_s_write", {31'd0, s_write}, 32'd0);
    check("rst_m_readdata", m_readdata, 32'd0);
    check("rst_txn_count", {16'd0, txn_count}, 32'd0);
    check("rst_protocol_error", {31'd0, protocol_error}, 32'd0);
    check("rst_s_address", s_address, 32'd0);
    check("rst_waitrequest_idle", {31'd0, m_waitrequest}, 32'd0);

    // No stalls, zero-wait slave: DONE lands exactly in cycle 2
    n_m_read = 1'b1; n_m_address = 32'h0000_0010; n_m_byteenable = 4'hF;
    @(negedge clk);
    check("t1_wait_c0", {31'd0, n_m_waitrequest}, 32'd1);
    @(negedge clk);
    check("t1_wait_c1", {31'd0, n_m_waitrequest}, 32'd1);
    check("t1_s_read_c1", {31'd0, n_s_read}, 32'd1);
    check("t1_s_addr_c1", n_s_address, 32'h0000_0010);
    @(negedge clk);
    check("t1_wait_c2", {31'd0, n_m_waitrequest}, 32'd0);
    check("t1_rdata", n_m_readdata, 32'hDEADBEEF);
    tick();
    n_m_read = 1'b0;
    check("t1_txn_count", {16'd0, n_txn_count}, 32'd1);

    // Random reads and writes against the reference RAM
    for (int i = 0; i < 200; i++) begin
      xfer(1'($urandom_range(0, 1)),
           {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 7) << 12),
           4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 3));
    end
    idle();
    tick();
    check("t2_txn_count", {16'd0, txn_count}, 32'd200);
    check("t2_protocol_error", {31'd0, protocol_error}, 32'd0);

    // Partial write through a slave that stalls 5 cycles, then read it back
    xfer(1'b1, 32'h0000_0024, 4'hF, 32'h0, 0);
    xfer(1'b0, 32'h0000_0024, 4'b0011, 32'h1234_5678, 5);
    xfer(1'b1, 32'h0000_0024, 4'hF, 32'h0, 2);
    idle();
    check("t3_ref_merge", ref_ram[9] & 32'h0000_FFFF, 32'h0000_5678);
    check("t3_protocol_error", {31'd0, protocol_error}, 32'd0);

    // Address changes while the bridge is stalling
    tick();
    n = 0;
    while (lfsr_m[7:0] % 8 == 0 && n < 100) begin tick(); n++; end
    stall = int'(lfsr_m[7:0]) % 8;
    push_exp(1'b1, 32'h0000_0024, 4'hF, 32'h0, 0);
    drive(1'b1, 32'h0000_0024, 4'hF, 32'h0);
    tick();
    check("t4_pe_before", {31'd0, protocol_error}, 32'd0);
    m_address = 32'h0000_0028;
    tick();
    check("t4_pe_set", {31'd0, protocol_error}, 32'd1);
    check("t4_in_stall_strobe", {31'd0, s_read | (stall == 1 ? 1'b0 : s_write)}, {31'd0, stall == 1});
    m_address = 32'h0000_0024;
    wait_done(busy);
    idle();
    repeat (4) tick();
    check("t4_pe_sticky", {31'd0, protocol_error}, 32'd1);

    // Reset while a read is stuck in ISSUE
    push_exp(1'b1, 32'h0000_0024, 4'hF, 32'h0, 20);
    drive(1'b1, 32'h0000_0024, 4'hF, 32'h0);
    n = 0;
    while (s_read !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("t6_reach_issue");
    #2 reset = 1'b1;
    #1;
    check("t6_s_read", {31'd0, s_read}, 32'd0);
    check("t6_m_readdata", m_readdata, 32'd0);
    check("t6_txn_count", {16'd0, txn_count}, 32'd0);
    check("t6_protocol_error", {31'd0, protocol_error}, 32'd0);
    sb.delete();
    idle();
    tick(); tick();
    reset = 1'b0;
    xfer(1'b1, 32'h0000_0024, 4'hF, 32'h0, 1);
    idle();
    tick();
    check("t6_txn_after", {16'd0, txn_count}, 32'd1);

    // Read and write asserted together while idle
    m_read = 1'b1; m_write = 1'b1; m_address = 32'h0000_0004; m_byteenable = 4'hF;
    tick();
    check("t5_pe", {31'd0, protocol_error}, 32'd1);
    check("t5_wait_high", {31'd0, m_waitrequest}, 32'd1);
    tick(); tick();
    check("t5_no_strobe", {30'd0, s_read, s_write}, 32'd0);
    check("t5_no_txn", {16'd0, txn_count}, 32'd1);
    idle();
    xfer(1'b1, 32'h0000_0024, 4'hF, 32'h0, 0);
    idle();
    tick();
    check("t5_txn_after", {16'd0, txn_count}, 32'd2);
    check("t5_sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
